// File: rtl/dvp_rx_pkg.sv
// Shared encodings for the DVP receiver: pixel formats, FSM states
// and the per-format last byte phase of a pixel.
package dvp_rx_pkg;

    typedef enum logic [1:0] {
        FMT_RGB565 = 2'd0,
        FMT_RGB888 = 2'd1,
        FMT_YUV_Y  = 2'd2,
        FMT_RAW8   = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        BLANK      = 2'd2,
        LINE       = 2'd3
    } state_e;

    function automatic logic [1:0] last_phase(fmt_e f);
        logic [1:0] r;
        case (f)
            FMT_RGB888: r = 2'd2;
            FMT_RAW8:   r = 2'd0;
            default:    r = 2'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dvp_pix_pack.sv
// Byte-to-pixel packer: holds earlier bytes of a pixel and maps the
// completed pixel to 24-bit {R,G,B} for the latched format.
import dvp_rx_pkg::*;

module dvp_pix_pack (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  phase_i,
    input  fmt_e        fmt_i,
    output logic [23:0] pixel_o,
    output logic        done_o
);

    logic [7:0]  b0_q;
    logic [7:0]  b1_q;
    logic [15:0] p565;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b0_q <= '0;
            b1_q <= '0;
        end else if (en_i) begin
            if (phase_i == 2'd0) b0_q <= byte_i;
            if (phase_i == 2'd1) b1_q <= byte_i;
        end
    end

    assign done_o = en_i && (phase_i == last_phase(fmt_i));
    assign p565   = {b0_q, byte_i};

    // YUYV: the Y byte sits at phase 0 and is emitted when the chroma byte lands
    always_comb begin
        pixel_o = '0;
        case (fmt_i)
            FMT_RGB565: pixel_o = {p565[15:11], 3'b0, p565[10:5], 2'b0,
                                   p565[4:0], 3'b0};
            FMT_RGB888: pixel_o = {b0_q, b1_q, byte_i};
            FMT_YUV_Y:  pixel_o = {3{b0_q}};
            FMT_RAW8:   pixel_o = {3{byte_i}};
            default:    pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/cmos_dvp_rx.sv
// DVP camera receiver: syncs sensor pins, skips start-up frames,
// packs bytes into pixels and measures frame geometry and errors.
import dvp_rx_pkg::*;

module cmos_dvp_rx #(
    parameter int DW         = 8,
    parameter int FRAME_SKIP = 5,
    parameter int CNT_W      = 12
) (
    input  logic             cmos_pclk_i,
    input  logic             rstn_i,
    input  logic             cmos_href_i,
    input  logic             cmos_vsync_i,
    input  logic [DW-1:0]    cmos_data_i,
    input  logic [1:0]       fmt_i,
    output logic [23:0]      rgb_o,
    output logic             de_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic [CNT_W-1:0] width_o,
    output logic [CNT_W-1:0] height_o,
    output logic [15:0]      frame_cnt_o,
    output logic             err_o
);

    localparam logic [7:0]       SKIP = 8'(FRAME_SKIP);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [2:0] href_q, vsync_q;
    logic [7:0] dat1_q, dat2_q;
    logic href_rise, href_fall, vs_rise;
    logic [7:0] skip_q, skip_d;
    logic out_en;
    state_e state_q, state_d;
    fmt_e fmt_q;
    logic [1:0] phase_q, phase_d, phase_cur;
    logic byte_v, pix_done;
    logic [23:0] pix;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, pix_base;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] first_w_q, first_w_d;
    logic [CNT_W-1:0] width_q, width_d, height_q, height_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic err_q, err_d;
    logic [23:0] rgb_q;
    logic de_q, hs_q, vs_q;
    logic line_end, frame_done;

    // Bits [1:0] synchronise, bit 2 is the edge-detect history
    always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            href_q  <= '0;
            vsync_q <= '0;
            dat1_q  <= '0;
            dat2_q  <= '0;
        end else begin
            href_q  <= {href_q[1:0], cmos_href_i};
            vsync_q <= {vsync_q[1:0], cmos_vsync_i};
            dat1_q  <= cmos_data_i[DW-1:DW-8];
            dat2_q  <= dat1_q;
        end
    end

    assign href_rise = href_q[1] & ~href_q[2];
    assign href_fall = ~href_q[1] & href_q[2];
    assign vs_rise   = vsync_q[1] & ~vsync_q[2];
    assign out_en    = (skip_q == SKIP);

    always_comb begin
        state_d = state_q;
        if (!out_en)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = WAIT_FRAME;
        else if (vs_rise)
            state_d = BLANK;
        else if (state_q == BLANK && href_rise)
            state_d = LINE;
        else if (state_q == LINE && href_fall)
            state_d = BLANK;
    end

    assign byte_v = href_q[1] && !vs_rise &&
                    (state_q == LINE || (state_q == BLANK && href_rise));
    assign phase_cur = href_rise ? 2'd0 : phase_q;

    dvp_pix_pack u_pack (
        .clk_i   (cmos_pclk_i),
        .rst_ni  (rstn_i),
        .en_i    (byte_v),
        .byte_i  (dat2_q),
        .phase_i (phase_cur),
        .fmt_i   (fmt_q),
        .pixel_o (pix),
        .done_o  (pix_done)
    );

    always_comb begin
        skip_d = (vs_rise && !out_en) ? skip_q + 8'd1 : skip_q;
        phase_d = 2'd0;
        if (byte_v && !pix_done) phase_d = phase_cur + 2'd1;
        pix_base  = href_rise ? '0 : pix_cnt_q;
        pix_cnt_d = pix_base;
        if (pix_done && pix_base != CMAX) pix_cnt_d = pix_base + 1'b1;
        line_end   = (state_q == LINE) && href_fall && !vs_rise;
        frame_done = vs_rise && line_cnt_q != '0 &&
                     (state_q == BLANK || state_q == LINE);
        line_cnt_d = line_cnt_q;
        first_w_d  = first_w_q;
        err_d      = err_q;
        width_d    = width_q;
        height_d   = height_q;
        fcnt_d     = fcnt_q;
        // A vsync rise inside a line aborts it and flags the new frame
        if (vs_rise && state_q != IDLE) begin
            line_cnt_d = '0;
            err_d      = (state_q == LINE);
        end else if (line_end) begin
            if (line_cnt_q != CMAX) line_cnt_d = line_cnt_q + 1'b1;
            if (line_cnt_q == '0) first_w_d = pix_cnt_q;
            else if (pix_cnt_q != first_w_q) err_d = 1'b1;
            if (phase_q != 2'd0) err_d = 1'b1;
        end
        if (frame_done) begin
            width_d  = first_w_q;
            height_d = line_cnt_q;
            fcnt_d   = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge cmos_pclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            skip_q     <= '0;
            state_q    <= IDLE;
            fmt_q      <= FMT_RGB565;
            phase_q    <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            first_w_q  <= '0;
            width_q    <= '0;
            height_q   <= '0;
            fcnt_q     <= '0;
            err_q      <= 1'b0;
            rgb_q      <= '0;
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else begin
            skip_q     <= skip_d;
            state_q    <= state_d;
            if (vs_rise) fmt_q <= fmt_e'(fmt_i);
            phase_q    <= phase_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            first_w_q  <= first_w_d;
            width_q    <= width_d;
            height_q   <= height_d;
            fcnt_q     <= fcnt_d;
            err_q      <= err_d;
            if (pix_done) rgb_q <= pix;
            de_q       <= pix_done & out_en;
            hs_q       <= href_q[1] & out_en;
            vs_q       <= vsync_q[1] & out_en;
        end
    end

    assign rgb_o       = rgb_q;
    assign de_o        = de_q;
    assign hs_o        = hs_q;
    assign vs_o        = vs_q;
    assign width_o     = width_q;
    assign height_o    = height_q;
    assign frame_cnt_o = fcnt_q;
    assign err_o       = err_q;

endmodule

// File: doc/cmos_dvp_rx.md
CMOS_DVP_RX -- requirements
Module: cmos_dvp_rx

Interface
REQ-001 SHALL have parameter DW, default 8: sensor data-bus width in bits, legal values 8 or 10; when 10, only bits [DW-1:DW-8] are used.
REQ-002 SHALL have parameter FRAME_SKIP, default 5: number of vsync rising edges discarded after reset, legal range 0..255.
REQ-003 SHALL have parameter CNT_W, default 12: width of the pixel and line counters.
REQ-004 SHALL have port cmos_pclk_i, input, 1 bit: sensor pixel clock; this is the only clock.
REQ-005 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cmos_href_i, input, 1 bit: line valid.
REQ-007 SHALL have port cmos_vsync_i, input, 1 bit: frame sync, active high.
REQ-008 SHALL have port cmos_data_i, input, DW bits: sensor byte.
REQ-009 SHALL have port fmt_i, input, 2 bits: pixel format; 0=RGB565, 1=RGB888, 2=YUV422 Y-only, 3=RAW8.
REQ-010 SHALL have port rgb_o, output, 24 bits: pixel, {R,G,B}.
REQ-011 SHALL have ports de_o, hs_o and vs_o, outputs, 1 bit each: pixel valid, line active and frame sync.
REQ-012 SHALL have ports width_o and height_o, outputs, CNT_W bits each: pixels per line and lines of the last completed frame.
REQ-013 SHALL have port frame_cnt_o, output, 16 bits: count of frames output.
REQ-014 SHALL have port err_o, output, 1 bit: sticky error for the current frame.

Function
REQ-015 SHALL register href, vsync and data through two cmos_pclk_i flops before any use.
REQ-016 SHALL count vsync rising edges up to FRAME_SKIP and saturate there; out_en SHALL be high once the count equals FRAME_SKIP, and with FRAME_SKIP=0 out_en SHALL be high from the first edge.
REQ-017 SHALL implement the FSM states IDLE, WAIT_FRAME, BLANK and LINE.
REQ-018 SHALL hold the FSM in IDLE while out_en is low.
REQ-019 SHALL move the FSM from IDLE to WAIT_FRAME when out_en goes high.
REQ-020 SHALL move the FSM from WAIT_FRAME to BLANK on a vsync rise.
REQ-021 SHALL move the FSM from BLANK to LINE on an href rise.
REQ-022 SHALL move the FSM from LINE back to BLANK on an href fall.
REQ-023 SHALL move the FSM to BLANK from any non-IDLE state on a vsync rise.
REQ-024 SHALL latch fmt_i only on a vsync rise, so a change to fmt_i mid-frame has no effect until the next frame.
REQ-025 SHALL pack bytes with a byte-phase counter cleared on every href rise: 2 bytes per pixel for RGB565 and YUV, 3 for RGB888, 1 for RAW8.
REQ-026 SHALL map an RGB565 pixel (first byte = MSB) to rgb_o = {p[15:11],3'b0, p[10:5],2'b0, p[4:0],3'b0}.
REQ-027 SHALL map an RGB888 pixel, bytes b0,b1,b2, to rgb_o = {b0,b1,b2}.
REQ-028 SHALL treat YUV422 bytes in YUYV order, use only the Y byte (even phase), and output rgb_o = {Y,Y,Y}, giving one pixel per 2 bytes.
REQ-029 SHALL output a RAW8 byte d as rgb_o = {d,d,d}.
REQ-030 SHALL register rgb_o and de_o, with de_o high for exactly one cycle per completed pixel; latency from the last byte of a pixel at the pins to de_o is 3 cycles.
REQ-031 SHALL delay hs_o and vs_o to align with de_o (3 cycles) and gate them, together with de_o, by out_en.
REQ-032 SHALL keep a per-line pixel counter and a per-frame line counter, both saturating at 2^CNT_W-1.
REQ-033 SHALL, on a vsync rise following a completed frame, load width_o from the first line's pixel count and height_o from the line count, and increment frame_cnt_o, which wraps modulo 2^16.
REQ-034 SHALL set err_o when an href fall leaves a partial pixel; the partial pixel is dropped and de_o is not asserted for it.
REQ-035 SHALL set err_o when a line's pixel count differs from the first line of the frame.
REQ-036 SHALL set err_o when a vsync rise arrives while in LINE; the line is aborted and not counted.
REQ-037 SHALL clear err_o on the vsync rise that starts the next frame, and SHALL set it again in the same cycle if that same vsync rise aborts a line.

Reset
REQ-038 SHALL, while rstn_i is low, hold all outputs, counters, sync flops and the FSM at 0/IDLE, with rgb_o = 0 and err_o = 0.
REQ-039 SHALL, after reset is asserted mid-frame, restart the frame-skip count and produce no partial-frame output.

Structure
REQ-040 SHALL place the fmt encodings (FMT_RGB565, FMT_RGB888, FMT_YUV_Y, FMT_RAW8) and the FSM state constants in shared package dvp_rx_pkg.
REQ-041 SHALL implement byte packing and format mapping in sub-module dvp_pix_pack (inputs: byte, phase, fmt; outputs: pixel, done).

Verification
REQ-042 SHALL cover: FRAME_SKIP=5, 7 frames, RGB565 4x2 -> no de_o in frames 1-5; frames 6-7 give 8 de_o pulses each; byte pair 0xF8,0x00 -> rgb_o=0xF80000.
REQ-043 SHALL cover: RGB888 bytes 0x12,0x34,0x56 -> rgb_o=0x123456, de_o 3 cycles after 0x56 at the pins.
REQ-044 SHALL cover: YUV bytes 0x80,0x10,0x40,0x20 -> two pixels 0x808080 and 0x404040.
REQ-045 SHALL cover: RGB565 line of 7 bytes -> 3 pixels and err_o=1; err_o returns to 0 after the next vsync rise.
REQ-046 SHALL cover: 640x480 RAW8 frame -> width_o=640, height_o=480, frame_cnt_o incremented by 1 at the next vsync.
REQ-047 SHALL cover: rstn_i pulsed low mid-line -> all outputs 0 immediately, and FRAME_SKIP frames are skipped again before output resumes.
